// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter driving a shared 8:1 mux select
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   req   in   [7:0] per-channel request
//   hold  in   [HOLD_W-1:0] max consecutive grant cycles per tenure (0 acts as 1)
//   gnt   out  [7:0] registered one-hot grant (zero when idle)
//   sel   out  [2:0] registered mux select, 7-index of granted channel
//   busy  out  registered, high whenever a channel is granted
module rr_mux_arbiter #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        req,
    input  logic [HOLD_W-1:0] hold,
    output logic [7:0]        gnt,
    output logic [2:0]        sel,
    output logic              busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        cur_q, cur_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        gnt_d;
    logic [2:0]        sel_d;
    logic              busy_d;

    logic              found;
    logic [2:0]        win;
    logic [2:0]        idx;
    logic [HOLD_W-1:0] hold_eff;
    logic              rel;
    logic              start;

    // Rotating priority search starting at ptr. Since ptr sits one past the
    // current owner, the owner is searched last, which gives the re-grant on
    // expiry when it is the only requester.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign hold_eff = (hold == '0) ? HOLD_W'(1) : hold;

    // Drop and expiry collapse into one release event, so ptr advances once.
    assign rel   = (state_q == GRANT) && (!req[cur_q] || (cnt_q == hold_q));
    assign start = found && ((state_q == IDLE) || rel);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        gnt_d   = gnt;
        sel_d   = sel;
        busy_d  = busy;

        if (start) begin
            state_d = GRANT;
            cur_d   = win;
            ptr_d   = win + 3'd1;
            cnt_d   = HOLD_W'(1);
            hold_d  = hold_eff;
            gnt_d   = 8'(1) << win;
            sel_d   = ~win;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                end
                GRANT: begin
                    if (rel) begin
                        // Nobody else wants the mux; sel keeps its last value.
                        state_d = IDLE;
                        cnt_d   = '0;
                        gnt_d   = 8'h00;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + HOLD_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            cur_q   <= 3'd0;
            cnt_q   <= '0;
            hold_q  <= '0;
            gnt     <= 8'h00;
            sel     <= 3'b111;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            gnt     <= gnt_d;
            sel     <= sel_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [3:0] hold;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       inv_en = 1'b0;

    int errors = 0;
    int checks = 0;

    rr_mux_arbiter #(.HOLD_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .hold (hold),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] gnt_index(input logic [7:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++)
            if (g[i]) r = 3'(i);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 8'h00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (inv_en && !rst) begin
            check("onehot0", 32'($onehot0(gnt)), 32'd1);
            check("busy_eq_or_gnt", 32'(busy), 32'(|gnt));
            if (busy)
                check("sel_eq_7_minus_idx", 32'(sel), 32'(3'd7 - gnt_index(gnt)));
        end
    end

    logic [7:0] exp_alt [8] = '{8'h01, 8'h01, 8'h80, 8'h80, 8'h01, 8'h01, 8'h80, 8'h80};

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        hold = 4'd0;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'h00);
        check("rst_sel", 32'(sel), 32'd7);
        check("rst_busy", 32'(busy), 32'd0);
        rst    = 1'b0;
        inv_en = 1'b1;

        // Two requesters, hold=2: alternate ch0/ch7 without gaps
        req  = 8'h81;
        hold = 4'd2;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("alt_gnt", 32'(gnt), 32'(exp_alt[i]));
            check("alt_sel", 32'(sel), (exp_alt[i] == 8'h01) ? 32'd7 : 32'd0);
        end

        // Single requester, hold=3: continuous grant across re-grants
        do_reset();
        req  = 8'h10;
        hold = 4'd3;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("single_gnt", 32'(gnt), 32'h10);
            check("single_sel", 32'(sel), 32'd3);
            check("single_busy", 32'(busy), 32'd1);
        end

        // Early drop, no preemption, and mid-tenure hold change ignored
        do_reset();
        req  = 8'h04;
        hold = 4'd15;
        tick();
        check("drop_first_gnt", 32'(gnt), 32'h04);
        check("drop_first_sel", 32'(sel), 32'd5);
        req  = 8'h24;
        hold = 4'd1;
        tick();
        check("nopreempt_gnt1", 32'(gnt), 32'h04);
        tick();
        check("nopreempt_gnt2", 32'(gnt), 32'h04);
        req = 8'h20;
        tick();
        check("drop_next_gnt", 32'(gnt), 32'h20);
        check("drop_next_sel", 32'(sel), 32'd2);
        req = 8'h00;
        tick();
        check("idle_gnt", 32'(gnt), 32'h00);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_sel_hold", 32'(sel), 32'd2);

        // hold=0 acts as 1: one cycle per channel, wrap 7->0
        do_reset();
        hold = 4'd0;
        req  = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("hold0_gnt", 32'(gnt), 32'(8'(1) << (i % 8)));
        end

        // Asynchronous reset during a ch3 tenure
        do_reset();
        hold = 4'd15;
        req  = 8'h08;
        tick();
        check("ch3_gnt", 32'(gnt), 32'h08);
        check("ch3_sel", 32'(sel), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        check("arst_gnt", 32'(gnt), 32'h00);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_sel", 32'(sel), 32'd7);
        req = 8'h0C;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_gnt", 32'(gnt), 32'h04);
        check("post_rst_sel", 32'(sel), 32'd5);
        check("post_rst_busy", 32'(busy), 32'd1);

        inv_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
